// File: rtl/seq_muldiv_unit_if.sv
// Start/Busy/Done handshake and operand/result bus of the sequential multiply/divide unit.
interface seq_muldiv_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        DivZero;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, Result, DivZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, Result, DivZero
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative 32-bit unsigned shift-add multiplier / restoring divider, one bit per clock.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply finishes once the multiplier is exhausted).
module seq_muldiv_unit (
  input  logic            Clock,
  input  logic            rst,
  seq_muldiv_unit_if.slave mdu_io
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;

  state_t                  state_q;
  logic [1:0]              op_q;
  logic [4:0]              cnt_q;
  logic [2*DATA_W-1:0]     m_q, p_q;
  logic [DATA_W-1:0]       q_q, qd_q, b_q, result_q;
  logic [DATA_W:0]         r_q;
  logic                    busy_q, done_q, divzero_q;

  logic [2*DATA_W-1:0]     m_d, p_d;
  logic [DATA_W-1:0]       q_d, qd_d, result_d;
  logic [DATA_W:0]         r_d, r_shift, r_trial;
  logic                    last_d;
  logic                    op_div0;

  // One iteration of both datapaths; op_q selects which one is meaningful.
  always_comb begin
    p_d     = q_q[0] ? (p_q + m_q) : p_q;
    m_d     = m_q << 1;
    q_d     = q_q >> 1;
    r_shift = {r_q[DATA_W-1:0], qd_q[DATA_W-1]};
    r_trial = r_shift - {1'b0, b_q};
    if (!r_trial[DATA_W]) begin
      r_d  = r_trial;
      qd_d = {qd_q[DATA_W-2:0], 1'b1};
    end else begin
      r_d  = r_shift;
      qd_d = {qd_q[DATA_W-2:0], 1'b0};
    end
    last_d = (cnt_q == 5'd31);
`ifdef MULDIV_EARLY_OUT_EN
    if (!op_q[1] && (q_d == '0)) last_d = 1'b1;
`endif
    case (op_q)
      OP_MUL:  result_d = p_d[DATA_W-1:0];
      OP_MULH: result_d = p_d[2*DATA_W-1:DATA_W];
      OP_DIVU: result_d = qd_d;
      default: result_d = r_d[DATA_W-1:0];
    endcase
  end

  assign op_div0 = mdu_io.Op[1] && (mdu_io.B == '0);

  always_ff @(posedge Clock) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      m_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      qd_q      <= '0;
      b_q       <= '0;
      r_q       <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (mdu_io.Start) begin
            op_q      <= mdu_io.Op;
            cnt_q     <= '0;
            m_q       <= {{DATA_W{1'b0}}, mdu_io.A};
            q_q       <= mdu_io.B;
            p_q       <= '0;
            r_q       <= '0;
            qd_q      <= mdu_io.A;
            b_q       <= mdu_io.B;
            divzero_q <= 1'b0;
            if (op_div0) begin
              // Division by zero resolves without iterating.
              state_q   <= DONE;
              done_q    <= 1'b1;
              divzero_q <= 1'b1;
              result_q  <= mdu_io.Op[0] ? mdu_io.A : '1;
`ifdef MULDIV_EARLY_OUT_EN
            end else if (!mdu_io.Op[1] && (mdu_io.B == '0)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= '0;
`endif
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          m_q   <= m_d;
          p_q   <= p_d;
          q_q   <= q_d;
          r_q   <= r_d;
          qd_q  <= qd_d;
          cnt_q <= cnt_q + 5'd1;
          if (last_d) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_io.Busy    = busy_q;
  assign mdu_io.Done    = done_q;
  assign mdu_io.Result  = result_q;
  assign mdu_io.DivZero = divzero_q;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Scoreboard bench for seq_muldiv_unit: driver pushes reference results, a monitor pops them on Done.
module tb_seq_muldiv_unit;
  logic clk = 1'b0;
  logic rst;

  seq_muldiv_unit_if bus ();

  seq_muldiv_unit dut (
    .Clock  (clk),
    .rst    (rst),
    .mdu_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          edges;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic last_b2b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic and the edge count at which DONE is entered.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] prod;
    prod    = 64'(a) * 64'(b);
    e.dz    = 1'b0;
    e.acc   = 0;
    e.edges = 32;
    case (op)
      2'b00: e.res = prod[31:0];
      2'b01: e.res = prod[63:32];
      2'b10: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: e.res = (b == 0) ? a : a % b;
    endcase
    if (op[1] && b == 0) begin
      e.dz    = 1'b1;
      e.edges = 0;
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      e.edges = 0;
      for (int i = 0; i < 32; i++) if (b[i]) e.edges = i + 1;
    end
`endif
    return e;
  endfunction

  // Called at a negedge while the unit is not busy.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e        = model(op, a, b);
    last_b2b = bus.Done;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    bus.Start = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.Busy && n < 200);
    chk("wait_ready_timeout", 64'(bus.Busy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (bus.Done) begin
      chk("busy_in_done", 64'(bus.Busy), 64'(0));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=Done expected=no Done");
      end else begin
        mon_e = sb.pop_front();
        chk("result", 64'(bus.Result), 64'(mon_e.res));
        chk("divzero", 64'(bus.DivZero), 64'(mon_e.dz));
        chk("done_edges", 64'(cyc - mon_e.acc), 64'(mon_e.edges));
      end
    end
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          n;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = '0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'(0));
    chk("rst_done", 64'(bus.Done), 64'(0));
    chk("rst_result", 64'(bus.Result), 64'(0));
    chk("rst_divzero", 64'(bus.DivZero), 64'(0));
    rst = 1'b0;
    wait_ready();

    issue(2'b00, 32'h7, 32'h6);
    wait_ready();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready();

    issue(2'b10, 32'd100, 32'd7);
    wait_ready();
    issue(2'b11, 32'd100, 32'd7);
    chk("b2b_no_idle", 64'(last_b2b), 64'(1));
    wait_ready();

    issue(2'b10, 32'h1234, 32'h0);
    wait_ready();
    issue(2'b11, 32'h1234, 32'h0);
    chk("div0_b2b", 64'(last_b2b), 64'(1));
    wait_ready();
    issue(2'b00, 32'd3, 32'd4);
    @(negedge clk);
    chk("divzero_clear", 64'(bus.DivZero), 64'(0));
    wait_ready();
    repeat (3) @(negedge clk);
    chk("result_hold", 64'(bus.Result), 64'(12));

    // Start pulsed mid-RUN with other operands must be ignored.
    issue(2'b00, 32'h0001_1111, 32'h0000_2222);
    repeat (5) @(negedge clk);
    bus.Op    = 2'b10;
    bus.A     = 32'hABCD;
    bus.B     = 32'd3;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_ready();

    issue(2'b10, 32'hDEAD_BEEF, 32'h13);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.Busy), 64'(0));
    chk("abort_result", 64'(bus.Result), 64'(0));
    chk("abort_done", 64'(bus.Done), 64'(0));
    sb.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    wait_ready();

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 255);
        2: rb = ra;
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 9 == 4) ra = 32'h0;
      issue(rop, ra, rb);
      wait_ready();
      if ($urandom_range(0, 2) == 0) repeat (2) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
